// File: rtl/ov7670_capture_ctrl.sv
// OV7670 -> AL422 frame-capture sequencer: aligns to camera VSYNC, pulses the FIFO
// write-pointer reset, gates OV_WEN for exactly one frame and hands it to the reader.
module ov7670_capture_ctrl #(
    parameter int unsigned RST_PULSE   = 4,
    parameter int unsigned SKIP_FRAMES = 0,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             RUN_EN,
    input  logic             CONT_MODE,
    input  logic [CNT_W-1:0] FRAME_NUM,
    input  logic             OV_VSYNC,
    input  logic             R_IDLE,
    output logic             OV_WRRST,
    output logic             OV_WEN,
    output logic             WR_FRAME,
    output logic             BUSY,
    output logic             RUN_DONE,
    output logic [CNT_W-1:0] FRAME_CNT
);

    typedef enum logic [2:0] {
        StIdle,
        StSkip,
        StWrst,
        StWrite,
        StWaitRd
    } state_e;

    localparam logic [3:0]       SkipLast  = 4'(SKIP_FRAMES);
    localparam logic [3:0]       PulseLast = 4'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   vs_dly_q;
    logic                   vs_edge;
    logic [3:0]             skip_cnt_q, skip_cnt_d;
    logic [3:0]             step_cnt_q, step_cnt_d;
    logic                   wrrst_q, wrrst_d;
    logic                   wen_q, wen_d;
    logic                   wr_frame_q, wr_frame_d;
    logic                   busy_q, busy_d;
    logic                   run_done_q, run_done_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                   rearm;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], OV_VSYNC};
    assign vs_edge = sync_q[SYNC_STAGES-1] & ~vs_dly_q;
    assign rearm   = CONT_MODE && RUN_EN && ((FRAME_NUM == '0) || (frame_cnt_q < FRAME_NUM));

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        step_cnt_d  = step_cnt_q;
        wrrst_d     = wrrst_q;
        wen_d       = wen_q;
        wr_frame_d  = wr_frame_q;
        run_done_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            StIdle: begin
                if (RUN_EN) begin
                    state_d     = StSkip;
                    skip_cnt_d  = '0;
                    frame_cnt_d = '0;
                end
            end
            StSkip: begin
                // Abort has priority over a coincident aligning edge.
                if (!RUN_EN) begin
                    state_d    = StIdle;
                    run_done_d = 1'b1;
                end else if (vs_edge) begin
                    if (skip_cnt_q == SkipLast) begin
                        state_d    = StWrst;
                        step_cnt_d = '0;
                        wrrst_d    = 1'b0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 4'd1;
                    end
                end
            end
            StWrst: begin
                step_cnt_d = step_cnt_q + 4'd1;
                if (step_cnt_q == PulseLast) begin
                    state_d = StWrite;
                    wrrst_d = 1'b1;
                    wen_d   = 1'b1;
                end
            end
            StWrite: begin
                if (vs_edge) begin
                    state_d     = StWaitRd;
                    wen_d       = 1'b0;
                    wr_frame_d  = 1'b1;
                    frame_cnt_d = (frame_cnt_q == CntMax) ? frame_cnt_q : frame_cnt_q + CntOne;
                end
            end
            StWaitRd: begin
                if (R_IDLE) begin
                    wr_frame_d = 1'b0;
                    if (rearm) begin
                        state_d    = StSkip;
                        skip_cnt_d = '0;
                    end else begin
                        state_d    = StIdle;
                        run_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                skip_cnt_d  = '0;
                step_cnt_d  = '0;
                wrrst_d     = 1'b1;
                wen_d       = 1'b0;
                wr_frame_d  = 1'b0;
                frame_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            sync_q      <= '0;
            vs_dly_q    <= 1'b0;
            skip_cnt_q  <= '0;
            step_cnt_q  <= '0;
            wrrst_q     <= 1'b1;
            wen_q       <= 1'b0;
            wr_frame_q  <= 1'b0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            vs_dly_q    <= sync_q[SYNC_STAGES-1];
            skip_cnt_q  <= skip_cnt_d;
            step_cnt_q  <= step_cnt_d;
            wrrst_q     <= wrrst_d;
            wen_q       <= wen_d;
            wr_frame_q  <= wr_frame_d;
            busy_q      <= busy_d;
            run_done_q  <= run_done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign OV_WRRST  = wrrst_q;
    assign OV_WEN    = wen_q;
    assign WR_FRAME  = wr_frame_q;
    assign BUSY      = busy_q;
    assign RUN_DONE  = run_done_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl: drives VSYNC frames and checks each write window
// against the VSYNC rise it must align to, derived from the frame/skip arithmetic.
module tb_ov7670_capture_ctrl;

    localparam int unsigned RstPulse   = 4;
    localparam int unsigned SkipFrames = 2;
    localparam int unsigned CntW       = 8;
    localparam int unsigned SyncStages = 2;
    localparam int          Period     = 24;
    localparam int          HighCyc    = 3;
    localparam int          Stride     = SkipFrames + 2;
    localparam int          CntMax     = (1 << CntW) - 1;

    logic            SYS_CLK = 1'b0;
    logic            RST;
    logic            RUN_EN;
    logic            CONT_MODE;
    logic [CntW-1:0] FRAME_NUM;
    logic            OV_VSYNC;
    logic            R_IDLE;
    logic            OV_WRRST;
    logic            OV_WEN;
    logic            WR_FRAME;
    logic            BUSY;
    logic            RUN_DONE;
    logic [CntW-1:0] FRAME_CNT;

    ov7670_capture_ctrl #(
        .RST_PULSE  (RstPulse),
        .SKIP_FRAMES(SkipFrames),
        .CNT_W      (CntW),
        .SYNC_STAGES(SyncStages)
    ) dut (
        .SYS_CLK  (SYS_CLK),
        .RST      (RST),
        .RUN_EN   (RUN_EN),
        .CONT_MODE(CONT_MODE),
        .FRAME_NUM(FRAME_NUM),
        .OV_VSYNC (OV_VSYNC),
        .R_IDLE   (R_IDLE),
        .OV_WRRST (OV_WRRST),
        .OV_WEN   (OV_WEN),
        .WR_FRAME (WR_FRAME),
        .BUSY     (BUSY),
        .RUN_DONE (RUN_DONE),
        .FRAME_CNT(FRAME_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int rises  = 0;
    int rd_cnt = 0;
    int lo_len = 0;
    int base, rd0;
    logic wen_p   = 1'b0;
    logic wrrst_p = 1'b1;

    int start_q[$];
    int end_q[$];
    int pulse_q[$];
    int align_q[$];
    int fcnt_q[$];
    int wrf_q[$];

    // Observe outputs on the falling edge and log every write window.
    always @(negedge SYS_CLK) begin
        if (RUN_DONE === 1'b1) rd_cnt++;
        if (OV_WRRST === 1'b0) lo_len++;
        else if (lo_len != 0) begin
            pulse_q.push_back(lo_len);
            lo_len = 0;
        end
        if (OV_WEN && !wen_p) begin
            start_q.push_back(rises);
            align_q.push_back((!wrrst_p && OV_WRRST) ? 1 : 0);
        end
        if (!OV_WEN && wen_p) begin
            end_q.push_back(rises);
            fcnt_q.push_back(int'(FRAME_CNT));
            wrf_q.push_back(int'(WR_FRAME));
        end
        wen_p   = OV_WEN;
        wrrst_p = OV_WRRST;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic periods(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge SYS_CLK);
            #1 OV_VSYNC = 1'b1;
            rises++;
            repeat (HighCyc) @(posedge SYS_CLK);
            #1 OV_VSYNC = 1'b0;
            repeat (Period - HighCyc - 1) @(posedge SYS_CLK);
        end
        #1;
    endtask

    task automatic clear_log();
        start_q.delete();
        end_q.delete();
        pulse_q.delete();
        align_q.delete();
        fcnt_q.delete();
        wrf_q.delete();
    endtask

    // Frame k of a run must open on rise base+k*Stride+SkipFrames+1 and close on the next.
    task automatic check_windows(input string tag, input int b, input int n);
        int exp_start, exp_cnt;
        chk($sformatf("%s_nwin", tag), start_q.size(), n);
        for (int k = 0; k < n; k++) begin
            exp_start = b + k * Stride + SkipFrames + 1;
            exp_cnt   = (k + 1 > CntMax) ? CntMax : k + 1;
            if (k < start_q.size()) begin
                chk($sformatf("%s_start%0d", tag, k), start_q[k], exp_start);
                chk($sformatf("%s_align%0d", tag, k), align_q[k], 1);
            end
            if (k < pulse_q.size()) chk($sformatf("%s_pulse%0d", tag, k), pulse_q[k], RstPulse);
            if (k < end_q.size()) begin
                chk($sformatf("%s_end%0d", tag, k), end_q[k], exp_start + 1);
                chk($sformatf("%s_fcnt%0d", tag, k), fcnt_q[k], exp_cnt);
                chk($sformatf("%s_wrf%0d", tag, k), wrf_q[k], 1);
            end
        end
    endtask

    initial begin
        RST = 1'b1; RUN_EN = 1'b0; CONT_MODE = 1'b0; FRAME_NUM = '0;
        OV_VSYNC = 1'b0; R_IDLE = 1'b0;
        cycles(3);
        chk("rst_wrrst", OV_WRRST, 1);
        chk("rst_wen", OV_WEN, 0);
        chk("rst_wrframe", WR_FRAME, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rundone", RUN_DONE, 0);
        chk("rst_fcnt", FRAME_CNT, 0);
        RST = 1'b0;
        cycles(5);

        // Single shot
        clear_log(); base = rises; rd0 = rd_cnt; RUN_EN = 1'b1;
        cycles(2);
        chk("ss_busy_arm", BUSY, 1);
        periods(Stride);
        check_windows("ss", base, 1);
        chk("ss_wrframe", WR_FRAME, 1);
        chk("ss_fcnt", FRAME_CNT, 1);
        RUN_EN = 1'b0;
        cycles(3);
        chk("ss_wrframe_hold", WR_FRAME, 1);
        chk("ss_busy_wait", BUSY, 1);
        R_IDLE = 1'b1;
        cycles(1);
        R_IDLE = 1'b0;
        chk("ss_rundone", RUN_DONE, 1);
        chk("ss_wrframe_clr", WR_FRAME, 0);
        chk("ss_busy_end", BUSY, 0);
        cycles(1);
        chk("ss_rundone_1cyc", RUN_DONE, 0);
        chk("ss_rd_count", rd_cnt - rd0, 1);

        // Continuous, bounded to 3 frames, reader pulsed after each frame
        clear_log(); CONT_MODE = 1'b1; FRAME_NUM = 8'd3; base = rises; rd0 = rd_cnt;
        RUN_EN = 1'b1;
        for (int f = 0; f < 3; f++) begin
            periods(Stride);
            chk($sformatf("cb_wrframe%0d", f), WR_FRAME, 1);
            chk($sformatf("cb_fcnt%0d", f), FRAME_CNT, f + 1);
            @(negedge SYS_CLK) R_IDLE = 1'b1;
            cycles(1);
            R_IDLE = 1'b0;
            if (f == 2) RUN_EN = 1'b0;
            chk($sformatf("cb_rundone%0d", f), RUN_DONE, (f == 2) ? 1 : 0);
            chk($sformatf("cb_busy%0d", f), BUSY, (f == 2) ? 0 : 1);
        end
        periods(Stride);
        check_windows("cb", base, 3);
        chk("cb_fcnt_hold", FRAME_CNT, 3);
        chk("cb_busy_end", BUSY, 0);
        chk("cb_rd_count", rd_cnt - rd0, 1);

        // Continuous, unlimited: 300 frames then drop RUN_EN mid-frame
        clear_log(); FRAME_NUM = '0; R_IDLE = 1'b1; base = rises; rd0 = rd_cnt;
        RUN_EN = 1'b1;
        cycles(2);
        chk("cu_fcnt_clr", FRAME_CNT, 0);
        periods(300 * Stride);
        chk("cu_fcnt_sat", FRAME_CNT, CntMax);
        periods(SkipFrames + 1);
        chk("cu_in_write", OV_WEN, 1);
        RUN_EN = 1'b0;
        periods(1);
        check_windows("cu", base, 301);
        chk("cu_busy_end", BUSY, 0);
        chk("cu_fcnt_end", FRAME_CNT, CntMax);
        chk("cu_rd_count", rd_cnt - rd0, 1);
        periods(Stride);
        chk("cu_no_more", start_q.size(), 301);
        R_IDLE = 1'b0;

        // Abort in SKIP before any edge
        rd0 = rd_cnt; RUN_EN = 1'b1;
        cycles(3);
        chk("ab_busy", BUSY, 1);
        chk("ab_fcnt_clr", FRAME_CNT, 0);
        RUN_EN = 1'b0;
        cycles(1);
        chk("ab_rundone", RUN_DONE, 1);
        chk("ab_busy_end", BUSY, 0);
        chk("ab_wrrst", OV_WRRST, 1);
        chk("ab_wen", OV_WEN, 0);
        chk("ab_fcnt", FRAME_CNT, 0);
        cycles(1);
        chk("ab_rd_count", rd_cnt - rd0, 1);

        // Async reset during WRITE, then clean restart with a sub-cycle VSYNC glitch
        CONT_MODE = 1'b0; RUN_EN = 1'b1;
        periods(SkipFrames + 1);
        chk("ar_in_write", OV_WEN, 1);
        @(negedge SYS_CLK);
        #1 RST = 1'b1;
        #1;
        chk("ar_wen", OV_WEN, 0);
        chk("ar_wrrst", OV_WRRST, 1);
        chk("ar_busy", BUSY, 0);
        chk("ar_rundone", RUN_DONE, 0);
        cycles(2);
        RST = 1'b0;
        clear_log(); base = rises; rd0 = rd_cnt;
        periods(1);
        @(posedge SYS_CLK);
        #3 OV_VSYNC = 1'b1;
        #2 OV_VSYNC = 1'b0;
        periods(Stride - 1);
        check_windows("ar", base, 1);
        chk("ar_wrframe", WR_FRAME, 1);
        RUN_EN = 1'b0;
        @(negedge SYS_CLK) R_IDLE = 1'b1;
        cycles(1);
        R_IDLE = 1'b0;
        chk("ar_rundone_end", RUN_DONE, 1);
        chk("ar_busy_end", BUSY, 0);
        cycles(2);
        chk("ar_rd_count", rd_cnt - rd0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
